// File: rtl/sn54170_pkg.sv
// Shared types and constants for the SN54170 register-file bus master.
package sn54170_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WSETUP,
        WPULSE,
        WHOLD,
        RSETUP,
        RSAMPLE,
        RESP
    } state_t;

    // Value the latch file presents on its outputs while reads are disabled.
    localparam logic [31:0] RF_IDLE_DATA = '1;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sn54170_phase_timer.sv
// Loadable down-counter; done is high while the count is zero.
module sn54170_phase_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sn54170_bus_master.sv
// Request/response initiator driving an SN54170-style 4x4 latch register file.
// Optional write readback check: define RF_READBACK_VERIFY_EN.
module sn54170_bus_master
    import sn54170_pkg::*;
#(
    parameter int unsigned DATA_W    = 4,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rf_wr_enb_n,
    output logic [ADDR_W-1:0] rf_wr_sel,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_rd_enb_n,
    output logic [ADDR_W-1:0] rf_rd_sel,
    input  logic [DATA_W-1:0] rf_data_out
);

    localparam int unsigned MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    if (SETUP_CYC == 0 || PULSE_CYC == 0 || HOLD_CYC == 0) begin : g_bad_cycles
        $error("sn54170_bus_master: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end

    state_t           state_q, state_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;
    logic             accept;

    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    sn54170_phase_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .done    (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Each timed phase reloads the timer on the transition into it.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                    state_d  = (req_wr == OP_RD) ? RSETUP : WSETUP;
                end
            end
            WSETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LD;
                    state_d  = WPULSE;
                end
            end
            WPULSE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                    state_d  = WHOLD;
                end
            end
            WHOLD: begin
                if (tmr_done) begin
`ifdef RF_READBACK_VERIFY_EN
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                    state_d  = RSETUP;
`else
                    state_d  = RESP;
`endif
                end
            end
            RSETUP: begin
                if (tmr_done) begin
                    state_d = RSAMPLE;
                end
            end
            RSAMPLE: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Enables and rsp_valid are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_enb_n <= 1'b1;
            rf_rd_enb_n <= 1'b1;
            rf_wr_sel   <= '0;
            rf_rd_sel   <= '0;
            rf_data_in  <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rf_wr_enb_n <= (state_d != WPULSE);
            rf_rd_enb_n <= !((state_d == RSETUP) || (state_d == RSAMPLE));
            rsp_valid   <= (state_d == RESP);
            if (accept) begin
                if (req_wr == OP_WR) begin
                    rf_wr_sel  <= req_addr;
                    rf_data_in <= req_wdata;
                end
`ifdef RF_READBACK_VERIFY_EN
                rf_rd_sel <= req_addr;
`else
                if (req_wr == OP_RD) begin
                    rf_rd_sel <= req_addr;
                end
`endif
            end
            if (state_q == RSAMPLE) begin
                rsp_rdata <= rf_data_out;
            end
        end
    end

`ifdef RF_READBACK_VERIFY_EN
    logic op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_RD;
            rsp_err <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= req_wr;
            end
            if (state_q == RSAMPLE) begin
                rsp_err <= (op_q == OP_WR) && (rf_data_out != rf_data_in);
            end
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sn54170_bus_master.sv
// Directed self-checking bench for sn54170_bus_master with a behavioural latch-file model.
module tb_sn54170_bus_master;
    import sn54170_pkg::*;

    localparam int DW = 4;
    localparam int AW = 2;
`ifdef RF_READBACK_VERIFY_EN
    localparam int  WR_LAT  = 7;
    localparam logic [19:0] WR_RD_MASK = 20'h00030;
`else
    localparam int  WR_LAT  = 5;
    localparam logic [19:0] WR_RD_MASK = 20'h00000;
`endif
    localparam int RD_LAT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rf_wr_enb_n;
    logic [AW-1:0] rf_wr_sel;
    logic [DW-1:0] rf_data_in;
    logic          rf_rd_enb_n;
    logic [AW-1:0] rf_rd_sel;
    logic [DW-1:0] rf_data_out;

    int checks = 0;
    int failures = 0;
    int overlap_cnt = 0;

    sn54170_bus_master #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rf_wr_enb_n(rf_wr_enb_n),
        .rf_wr_sel  (rf_wr_sel),
        .rf_data_in (rf_data_in),
        .rf_rd_enb_n(rf_rd_enb_n),
        .rf_rd_sel  (rf_rd_sel),
        .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    // Latch-file model: transparent while write enable is low; optional bit0 corruption on 4'h3.
    logic [DW-1:0] mem [4];
    logic          mem_clr = 1'b0;
    logic          corrupt_en = 1'b0;

    always @(rf_wr_enb_n, rf_wr_sel, rf_data_in, corrupt_en, mem_clr) begin
        if (mem_clr) begin
            for (int i = 0; i < 4; i++) mem[i] = DW'(RF_IDLE_DATA);
        end else if (!rf_wr_enb_n) begin
            mem[rf_wr_sel] = rf_data_in ^ ((corrupt_en && rf_data_in == 4'h3) ? 4'h1 : 4'h0);
        end
    end

    assign rf_data_out = rf_rd_enb_n ? DW'(RF_IDLE_DATA) : mem[rf_rd_sel];

    always @(negedge clk) begin
        if (rst_n && !rf_wr_enb_n && !rf_rd_enb_n) overlap_cnt++;
    end

    // Per-cycle samples, index n = cycles after the accept edge (taken 1 time unit after each edge).
    logic [19:0]   wr_mask, rd_mask, rsp_mask;
    logic [AW-1:0] s_wsel [20];
    logic [DW-1:0] s_din  [20];
    int            rsp_n;
    logic [DW-1:0] got_rdata;
    logic          got_err;

    // Latency is counted to the edge at which the requester first samples rsp_valid high.
    task automatic run_req(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = data;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = ~addr;
        req_wdata = ~data;
        wr_mask = '0; rd_mask = '0; rsp_mask = '0;
        rsp_n = -1; got_rdata = '0; got_err = 1'b0;
        for (int n = 0; n < 20; n++) begin
            wr_mask[n]  = !rf_wr_enb_n;
            rd_mask[n]  = !rf_rd_enb_n;
            rsp_mask[n] = rsp_valid;
            s_wsel[n]   = rf_wr_sel;
            s_din[n]    = rf_data_in;
            if (rsp_valid && rsp_n < 0) begin
                rsp_n     = n;
                got_rdata = rsp_rdata;
                got_err   = rsp_err;
            end
            if (n != 19) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        mem_clr = 1'b1; #1; mem_clr = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        obs = {rf_wr_enb_n, rf_rd_enb_n, rf_wr_sel, rf_rd_sel, rf_data_in,
               rsp_valid, rsp_rdata, rsp_err, req_ready};
        checks++;
        if (obs !== 17'b1_1_00_00_0000_0_0000_0_1) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", obs, 17'b1_1_00_00_0000_0_0000_0_1);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release ready=%b rsp_valid=%b exp ready=1 rsp_valid=0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_write();
        logic stable;
        run_req(1'b1, 2'd2, 4'hA);
        checks++;
        if (wr_mask !== 20'h00006) begin
            failures++;
            $display("FAIL write_pulse wr_low_mask=%h exp=%h", wr_mask, 20'h00006);
        end
        stable = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (s_wsel[n] !== 2'd2 || s_din[n] !== 4'hA) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL write_stable sel/data not 2/A through setup..hold sel0=%h din0=%h sel3=%h din3=%h",
                     s_wsel[0], s_din[0], s_wsel[3], s_din[3]);
        end
        checks++;
        if (rsp_n + 1 != WR_LAT) begin
            failures++;
            $display("FAIL write_latency got=%0d exp=%0d", rsp_n + 1, WR_LAT);
        end
        checks++;
        if ($countones(rsp_mask) != 1) begin
            failures++;
            $display("FAIL write_rsp_count got=%0d exp=1", $countones(rsp_mask));
        end
        checks++;
        if (rd_mask !== WR_RD_MASK) begin
            failures++;
            $display("FAIL write_rd_enable rd_low_mask=%h exp=%h", rd_mask, WR_RD_MASK);
        end
`ifdef RF_READBACK_VERIFY_EN
        checks++;
        if (got_rdata !== 4'hA || got_err !== 1'b0) begin
            failures++;
            $display("FAIL write_readback rdata=%h err=%b exp rdata=a err=0", got_rdata, got_err);
        end
`else
        checks++;
        if (got_rdata !== 4'h0 || got_err !== 1'b0) begin
            failures++;
            $display("FAIL write_rsp rdata=%h err=%b exp rdata=0 err=0", got_rdata, got_err);
        end
`endif
        checks++;
        if (mem[2] !== 4'hA) begin
            failures++;
            $display("FAIL write_mem mem[2]=%h exp=a", mem[2]);
        end
    endtask

    task automatic test_write_read();
        run_req(1'b1, 2'd1, 4'h5);
        run_req(1'b0, 2'd1, 4'h0);
        checks++;
        if (got_rdata !== 4'h5 || got_err !== 1'b0) begin
            failures++;
            $display("FAIL read_data rdata=%h err=%b exp rdata=5 err=0", got_rdata, got_err);
        end
        checks++;
        if (rsp_n + 1 != RD_LAT) begin
            failures++;
            $display("FAIL read_latency got=%0d exp=%0d", rsp_n + 1, RD_LAT);
        end
        checks++;
        if (rd_mask !== 20'h00003 || wr_mask !== 20'h00000) begin
            failures++;
            $display("FAIL read_enables rd_low_mask=%h wr_low_mask=%h exp 00003/00000", rd_mask, wr_mask);
        end
    endtask

    task automatic test_read_unwritten();
        run_req(1'b0, 2'd3, 4'h0);
        checks++;
        if (got_rdata !== 4'hF || got_err !== 1'b0 || rsp_n + 1 != RD_LAT) begin
            failures++;
            $display("FAIL read_unwritten rdata=%h err=%b lat=%0d exp rdata=f err=0 lat=%0d",
                     got_rdata, got_err, rsp_n + 1, RD_LAT);
        end
    endtask

    task automatic test_back_to_back();
        int acc_edge [4];
        int rsp_edge [4];
        int n_acc;
        int n_rsp;
        logic acc;
        logic [DW-1:0] wd [4];
        wd[0] = 4'h1; wd[1] = 4'h6; wd[2] = 4'hC; wd[3] = 4'h9;
        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            acc_edge[i] = 0;
            rsp_edge[i] = 0;
        end
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 2'd0; req_wdata = wd[0];
        for (int e = 1; e <= 80 && n_rsp < 4; e++) begin
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (n_acc < 4) acc_edge[n_acc] = e;
                n_acc++;
                if (n_acc < 4) begin
                    req_addr  = AW'(n_acc);
                    req_wdata = wd[n_acc];
                end else begin
                    req_valid = 1'b0;
                end
            end
            if (rsp_valid) begin
                if (n_rsp < 4) rsp_edge[n_rsp] = e;
                n_rsp++;
            end
        end
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (n_acc != 4 || n_rsp != 4) begin
            failures++;
            $display("FAIL b2b_counts accepts=%0d responses=%0d exp 4/4", n_acc, n_rsp);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_edge[i+1] - acc_edge[i] != WR_LAT + 1 || acc_edge[i+1] != rsp_edge[i] + 2) begin
                failures++;
                $display("FAIL b2b_spacing[%0d] accept_gap=%0d next_accept=%0d resp_edge=%0d exp gap=%0d",
                         i, acc_edge[i+1] - acc_edge[i], acc_edge[i+1], rsp_edge[i], WR_LAT + 1);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem[i] !== wd[i]) begin
                failures++;
                $display("FAIL b2b_mem[%0d] got=%h exp=%h", i, mem[i], wd[i]);
            end
        end
        checks++;
        if (overlap_cnt != 0) begin
            failures++;
            $display("FAIL enable_overlap cycles=%0d exp=0", overlap_cnt);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int rsp_seen;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 2'd0; req_wdata = 4'h9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rf_wr_enb_n !== 1'b0) begin
            failures++;
            $display("FAIL midreset_in_pulse wr_enb_n=%b exp=0", rf_wr_enb_n);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_wr_enb_n !== 1'b1 || rf_rd_enb_n !== 1'b1 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_async wr_enb_n=%b rd_enb_n=%b ready=%b exp 1/1/1",
                     rf_wr_enb_n, rf_rd_enb_n, req_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        rsp_seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if (rsp_seen != 0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_after rsp_cycles=%0d ready=%b exp 0/1", rsp_seen, req_ready);
        end
    endtask

`ifdef RF_READBACK_VERIFY_EN
    task automatic test_readback_verify();
        corrupt_en = 1'b1;
        run_req(1'b1, 2'd1, 4'h3);
        corrupt_en = 1'b0;
        checks++;
        if (got_err !== 1'b1 || got_rdata !== 4'h2 || rsp_n + 1 != 7) begin
            failures++;
            $display("FAIL readback_corrupt err=%b rdata=%h lat=%0d exp err=1 rdata=2 lat=7",
                     got_err, got_rdata, rsp_n + 1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_write_read();
        test_read_unwritten();
        test_back_to_back();
        test_reset_mid_pulse();
`ifdef RF_READBACK_VERIFY_EN
        test_readback_verify();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
